branch_resolve_unit: RTL and testbench

//  Execute-side branch/jump resolver: the producer of the resolution interface consumed by the bpu
//  (b_eval, branch_outcome, trgt_gen, alupc, jr_bpu, jr_in).

---
 rtl/branch_resolve_unit.sv | 249 ++++++++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//   Execute-side branch/jump resolver. Takes one branch/jump at a time from
//   decode, waits in HOLD until forwarded operands are valid, then evaluates
//   the condition and target. It drives the resolution interface consumed by
//   the bpu (b_eval/branch_outcome, trgt_gen/alupc, jr_bpu/jr_in), opens a
//   fetch-flush window on redirects, and keeps saturating branch and
//   mispredict counters.
//
// Handshake: an instruction is accepted on a rising clk edge where
//   in_valid & in_ready. in_ready is high only in IDLE. in_valid while
//   in_ready is low is ignored. Decode keeps the instruction presented until
//   it is accepted. On accept, kind/pc/imm/pred/valbit are captured. rs1/rs2
//   are sampled in the cycle opnd_rdy is high (the cycle leaving IDLE/HOLD).
//
// Ports
//   clk, nrst                 clock, synchronous active-low reset
//   in_valid/in_ready         decode handshake
//   in_kind                   0 BEQ,1 BNE,2 BLT,3 BGE,4 BLTU,5 BGEU,6 JAL,7 JALR
//   in_pc, in_imm             instruction PC and sign-extended offset
//   in_pred_taken, in_valbit  bpu prediction and validity bits from fetch
//   opnd_rdy, rs1, rs2        forwarded operands and their valid flag
//   b_eval, branch_outcome    conditional branch resolved / taken
//   trgt_gen                  JAL target produced
//   alupc, pcplf              taken target, pc+4
//   jr_bpu, jr_in             JALR target pulse and value
//   flush                     squash younger fetched instructions
//   br_cnt, mis_cnt           saturating performance counters
//   dbg_state                 current FSM state (0 IDLE,1 HOLD,2 RESOLVE,3 FLUSH)
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int PC_W         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_kind,
  input  logic [PC_W-1:0]  in_pc,
  input  logic [PC_W-1:0]  in_imm,
  input  logic             in_pred_taken,
  input  logic             in_valbit,
  input  logic             opnd_rdy,
  input  logic [PC_W-1:0]  rs1,
  input  logic [PC_W-1:0]  rs2,
  output logic             b_eval,
  output logic             branch_outcome,
  output logic             trgt_gen,
  output logic [PC_W-1:0]  alupc,
  output logic [PC_W-1:0]  pcplf,
  output logic             jr_bpu,
  output logic [PC_W-1:0]  jr_in,
  output logic             flush,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mis_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HOLD    = 2'd1,
    S_RESOLVE = 2'd2,
    S_FLUSH   = 2'd3
  } state_t;

  localparam logic [2:0] K_BEQ  = 3'd0;
  localparam logic [2:0] K_BNE  = 3'd1;
  localparam logic [2:0] K_BLT  = 3'd2;
  localparam logic [2:0] K_BGE  = 3'd3;
  localparam logic [2:0] K_BLTU = 3'd4;
  localparam logic [2:0] K_BGEU = 3'd5;
  localparam logic [2:0] K_JAL  = 3'd6;
  localparam logic [2:0] K_JALR = 3'd7;

  // Countdown holds FLUSH_CYCLES-1 .. 0 while in FLUSH.
  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t            r_state;
  state_t            w_next_state;

  logic [2:0]        r_kind;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   r_imm;
  logic              r_pred;
  logic              r_valbit;
  logic              r_redirect;
  logic [FC_W-1:0]   r_flush_cnt;

  logic              r_b_eval;
  logic              r_outcome;
  logic              r_trgt_gen;
  logic              r_jr_bpu;
  logic [PC_W-1:0]   r_alupc;
  logic [PC_W-1:0]   r_pcplf;
  logic [PC_W-1:0]   r_jr_in;
  logic [CNT_W-1:0]  r_br_cnt;
  logic [CNT_W-1:0]  r_mis_cnt;

  logic              w_accept;
  logic              w_fire;
  logic [2:0]        w_kind;
  logic [PC_W-1:0]   w_pc;
  logic [PC_W-1:0]   w_imm;
  logic              w_pred;
  logic              w_valbit;
  logic              w_is_cond;
  logic              w_is_jal;
  logic              w_is_jalr;
  logic              w_outcome;
  logic              w_mispredict;
  logic              w_redirect;
  logic [PC_W-1:0]   w_br_target;
  logic [PC_W-1:0]   w_jalr_sum;
  logic [PC_W-1:0]   w_jalr_target;

  assign w_accept = (r_state == S_IDLE) && in_valid;
  // Operands are sampled in whichever cycle leaves IDLE/HOLD towards RESOLVE.
  assign w_fire   = (w_accept && opnd_rdy) || ((r_state == S_HOLD) && opnd_rdy);

  // In IDLE the instruction is still on the inputs; in HOLD use the captured copy.
  assign w_kind   = (r_state == S_IDLE) ? in_kind       : r_kind;
  assign w_pc     = (r_state == S_IDLE) ? in_pc         : r_pc;
  assign w_imm    = (r_state == S_IDLE) ? in_imm        : r_imm;
  assign w_pred   = (r_state == S_IDLE) ? in_pred_taken : r_pred;
  assign w_valbit = (r_state == S_IDLE) ? in_valbit     : r_valbit;

  assign w_is_jal  = (w_kind == K_JAL);
  assign w_is_jalr = (w_kind == K_JALR);
  assign w_is_cond = !w_is_jal && !w_is_jalr;

  always_comb begin
    w_outcome = 1'b0;
    case (w_kind)
      K_BEQ:   w_outcome = (rs1 == rs2);
      K_BNE:   w_outcome = (rs1 != rs2);
      K_BLT:   w_outcome = ($signed(rs1) <  $signed(rs2));
      K_BGE:   w_outcome = ($signed(rs1) >= $signed(rs2));
      K_BLTU:  w_outcome = (rs1 <  rs2);
      K_BGEU:  w_outcome = (rs1 >= rs2);
      default: w_outcome = 1'b0;
    endcase
  end

  assign w_br_target   = w_pc + w_imm;
  assign w_jalr_sum    = rs1 + w_imm;
  assign w_jalr_target = {w_jalr_sum[PC_W-1:1], 1'b0};

  assign w_mispredict = w_is_cond && (w_pred ^ w_outcome);
  // A JAL the bpu did not know about was fetched past; a JALR target is never predicted.
  assign w_redirect   = w_mispredict || w_is_jalr || (w_is_jal && !w_valbit);

  // FSM state register
  always_ff @(posedge clk) begin
    if (!nrst) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // FSM next state and state-decoded outputs
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    flush        = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (w_accept) w_next_state = opnd_rdy ? S_RESOLVE : S_HOLD;
      end
      S_HOLD: begin
        if (opnd_rdy) w_next_state = S_RESOLVE;
      end
      S_RESOLVE: begin
        w_next_state = r_redirect ? S_FLUSH : S_IDLE;
      end
      S_FLUSH: begin
        flush = 1'b1;
        if (r_flush_cnt == '0) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Capture, resolution registers, flush countdown and counters
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_kind      <= '0;
      r_pc        <= '0;
      r_imm       <= '0;
      r_pred      <= 1'b0;
      r_valbit    <= 1'b0;
      r_redirect  <= 1'b0;
      r_flush_cnt <= '0;
      r_b_eval    <= 1'b0;
      r_outcome   <= 1'b0;
      r_trgt_gen  <= 1'b0;
      r_jr_bpu    <= 1'b0;
      r_alupc     <= '0;
      r_pcplf     <= '0;
      r_jr_in     <= '0;
      r_br_cnt    <= '0;
      r_mis_cnt   <= '0;
    end else begin
      r_b_eval   <= 1'b0;
      r_outcome  <= 1'b0;
      r_trgt_gen <= 1'b0;
      r_jr_bpu   <= 1'b0;

      if (w_accept) begin
        r_kind   <= in_kind;
        r_pc     <= in_pc;
        r_imm    <= in_imm;
        r_pred   <= in_pred_taken;
        r_valbit <= in_valbit;
      end

      if (w_fire) begin
        r_b_eval   <= w_is_cond;
        r_outcome  <= w_is_cond && w_outcome;
        r_trgt_gen <= w_is_jal;
        r_jr_bpu   <= w_is_jalr;
        r_alupc    <= w_is_jalr ? w_jalr_target : w_br_target;
        r_pcplf    <= w_pc + PC_W'(4);
        r_redirect <= w_redirect;
        if (w_is_jalr) r_jr_in <= w_jalr_target;
        if (w_is_cond && !(&r_br_cnt))     r_br_cnt  <= r_br_cnt + CNT_W'(1);
        if (w_mispredict && !(&r_mis_cnt)) r_mis_cnt <= r_mis_cnt + CNT_W'(1);
      end

      if (r_state == S_RESOLVE) begin
        r_flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
      end else if ((r_state == S_FLUSH) && (r_flush_cnt != '0)) begin
        r_flush_cnt <= r_flush_cnt - FC_W'(1);
      end
    end
  end

  assign b_eval         = r_b_eval;
  assign branch_outcome = r_outcome;
  assign trgt_gen       = r_trgt_gen;
  assign jr_bpu         = r_jr_bpu;
  assign alupc          = r_alupc;
  assign pcplf          = r_pcplf;
  assign jr_in          = r_jr_in;
  assign br_cnt         = r_br_cnt;
  assign mis_cnt        = r_mis_cnt;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  localparam int PC_W  = 32;
  localparam int FLUSH = 2;
  localparam int CNT_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_kind = '0;
  logic [PC_W-1:0]  in_pc = '0;
  logic [PC_W-1:0]  in_imm = '0;
  logic             in_pred_taken = 1'b0;
  logic             in_valbit = 1'b0;
  logic             opnd_rdy = 1'b0;
  logic [PC_W-1:0]  rs1 = '0;
  logic [PC_W-1:0]  rs2 = '0;
  logic             b_eval, branch_outcome, trgt_gen, jr_bpu, flush;
  logic [PC_W-1:0]  alupc, pcplf, jr_in;
  logic [CNT_W-1:0] br_cnt, mis_cnt;
  logic [1:0]       dbg_state;

  branch_resolve_unit #(.PC_W(PC_W), .FLUSH_CYCLES(FLUSH), .CNT_W(CNT_W)) dut (
    .clk(clk), .nrst(nrst),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_pc(in_pc), .in_imm(in_imm), .in_pred_taken(in_pred_taken), .in_valbit(in_valbit),
    .opnd_rdy(opnd_rdy), .rs1(rs1), .rs2(rs2),
    .b_eval(b_eval), .branch_outcome(branch_outcome), .trgt_gen(trgt_gen),
    .alupc(alupc), .pcplf(pcplf), .jr_bpu(jr_bpu), .jr_in(jr_in),
    .flush(flush), .br_cnt(br_cnt), .mis_cnt(mis_cnt), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Transaction-level view: an accepted instruction either resolves at once
  // or waits; the interval after resolution carries the pulses, then a
  // redirect is followed by FLUSH intervals with flush high. in_ready is high
  // only when nothing is pending, resolving or flushing.
  bit               m_started = 0;
  bit               m_holding = 0;
  int               m_after = 0;
  bit               m_ready = 1;
  bit               m_flush = 0;
  bit               m_beval = 0, m_out = 0, m_trgt = 0, m_jr = 0, m_vals = 0;
  logic [PC_W-1:0]  m_alupc = '0, m_pcplf = '0, m_jrin = '0;
  int               m_br = 0, m_mis = 0;
  logic [2:0]       h_kind;
  logic [PC_W-1:0]  h_pc, h_imm;
  bit               h_pred, h_vb;
  int               max_cnt = (1 << CNT_W) - 1;

  task automatic model_resolve(input logic [2:0] k, input logic [PC_W-1:0] pc, imm,
                               input bit pred, vb, input logic [PC_W-1:0] a, b);
    bit taken, cond, mis, redir;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    cond = (k <= 3'd5);
    case (k)
      3'd0: taken = (a == b);
      3'd1: taken = (a != b);
      3'd2: taken = (sa < sb);
      3'd3: taken = (sa >= sb);
      3'd4: taken = ({32'd0, a} < {32'd0, b});
      3'd5: taken = ({32'd0, a} >= {32'd0, b});
      default: taken = 0;
    endcase
    mis   = cond && (pred != taken);
    redir = mis || (k == 3'd7) || ((k == 3'd6) && !vb);
    m_beval = cond;
    m_out   = cond && taken;
    m_trgt  = (k == 3'd6);
    m_jr    = (k == 3'd7);
    m_vals  = 1;
    m_pcplf = pc + 32'd4;
    if (k == 3'd7) begin
      m_alupc = (a + imm) & ~32'd1;
      m_jrin  = m_alupc;
    end else begin
      m_alupc = pc + imm;
    end
    if (cond && m_br < max_cnt) m_br++;
    if (mis && m_mis < max_cnt) m_mis++;
    m_after   = redir ? FLUSH : 0;
    m_holding = 0;
    m_ready   = 0;
  endtask

  always @(posedge clk) begin
    bit prev_ready;
    m_started = 1;
    m_beval = 0; m_out = 0; m_trgt = 0; m_jr = 0; m_vals = 0;
    prev_ready = m_ready;
    m_flush = 0;
    if (!nrst) begin
      m_holding = 0; m_after = 0; m_ready = 1;
      m_br = 0; m_mis = 0;
      m_alupc = '0; m_pcplf = '0; m_jrin = '0;
      m_vals = 1;
    end else if (m_after > 0) begin
      m_flush = 1; m_after--; m_ready = 0;
    end else if (m_holding) begin
      if (opnd_rdy) model_resolve(h_kind, h_pc, h_imm, h_pred, h_vb, rs1, rs2);
      else m_ready = 0;
    end else if (prev_ready && in_valid) begin
      h_kind = in_kind; h_pc = in_pc; h_imm = in_imm; h_pred = in_pred_taken; h_vb = in_valbit;
      if (opnd_rdy) model_resolve(h_kind, h_pc, h_imm, h_pred, h_vb, rs1, rs2);
      else begin m_holding = 1; m_ready = 0; end
    end else begin
      m_ready = 1;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (m_started) begin
      chk("in_ready", in_ready, m_ready);
      chk("flush", flush, m_flush);
      chk("b_eval", b_eval, m_beval);
      chk("trgt_gen", trgt_gen, m_trgt);
      chk("jr_bpu", jr_bpu, m_jr);
      chk("br_cnt", br_cnt, m_br);
      chk("mis_cnt", mis_cnt, m_mis);
      if (m_beval) chk("branch_outcome", branch_outcome, m_out);
      if (m_vals) begin
        chk("alupc", alupc, m_alupc);
        chk("pcplf", pcplf, m_pcplf);
      end
      if (m_jr || (m_vals && !nrst)) chk("jr_in", jr_in, m_jrin);
    end
  end

  // ---------------- driver ----------------
  // Presents one instruction; opnd_rdy stays low for h cycles starting with
  // the accept cycle. Returns at the negedge of the resolution cycle.
  task automatic issue(input logic [2:0] k, input logic [PC_W-1:0] pc, imm,
                       input bit pred, vb, input logic [PC_W-1:0] a, b, input int h);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      chk("issue_ready_timeout", 1'b0, 1'b1);
      return;
    end
    in_valid = 1; in_kind = k; in_pc = pc; in_imm = imm;
    in_pred_taken = pred; in_valbit = vb;
    opnd_rdy = (h == 0);
    rs1 = (h == 0) ? a : $urandom;
    rs2 = (h == 0) ? b : $urandom;
    for (int i = 0; i < h; i++) begin
      @(negedge clk);
      // Captured fields must not follow these changes while held.
      in_valid = 1'($urandom_range(0, 1));
      in_kind = 3'($urandom); in_pc = $urandom; in_imm = $urandom;
      in_pred_taken = 1'($urandom); in_valbit = 1'($urandom);
      opnd_rdy = (i == h - 1);
      rs1 = (i == h - 1) ? a : $urandom;
      rs2 = (i == h - 1) ? b : $urandom;
    end
    @(negedge clk);
    in_valid = 0;
    opnd_rdy = 1'($urandom_range(0, 1));
    rs1 = $urandom; rs2 = $urandom;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0]      k;
    logic [PC_W-1:0] a, b, imm;
    int              h;

    repeat (3) step();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_flush", flush, 1'b0);
    chk("rst_alupc", alupc, 32'h0);
    chk("rst_br_cnt", br_cnt, 4'h0);
    nrst = 1;

    // BEQ equal, predicted taken
    issue(3'd0, 32'h100, 32'h20, 1, 0, 32'd5, 32'd5, 0);
    chk("t1_b_eval", b_eval, 1'b1);
    chk("t1_outcome", branch_outcome, 1'b1);
    chk("t1_alupc", alupc, 32'h120);
    chk("t1_pcplf", pcplf, 32'h104);
    chk("t1_br_cnt", br_cnt, 4'd1);
    chk("t1_mis_cnt", mis_cnt, 4'd0);
    step();
    chk("t1_no_flush", flush, 1'b0);
    chk("t1_ready", in_ready, 1'b1);

    // BLT signed -1 < 1, predicted not-taken -> mispredict
    issue(3'd2, 32'h400, 32'h10, 0, 0, 32'hFFFF_FFFF, 32'd1, 0);
    chk("t2_outcome", branch_outcome, 1'b1);
    chk("t2_mis_cnt", mis_cnt, 4'd1);
    chk("t2_ready_res", in_ready, 1'b0);
    step();
    chk("t2_flush1", flush, 1'b1);
    chk("t2_ready_f1", in_ready, 1'b0);
    step();
    chk("t2_flush2", flush, 1'b1);
    step();
    chk("t2_flush_end", flush, 1'b0);
    chk("t2_ready_end", in_ready, 1'b1);

    // BLTU same operands -> not taken
    issue(3'd4, 32'h400, 32'h10, 0, 0, 32'hFFFF_FFFF, 32'd1, 0);
    chk("t2u_b_eval", b_eval, 1'b1);
    chk("t2u_outcome", branch_outcome, 1'b0);
    chk("t2u_mis_cnt", mis_cnt, 4'd1);

    // BNE held for 3 cycles
    issue(3'd1, 32'h500, 32'h40, 1, 0, 32'd1, 32'd2, 3);
    chk("t3_b_eval", b_eval, 1'b1);
    chk("t3_outcome", branch_outcome, 1'b1);
    chk("t3_alupc", alupc, 32'h540);
    chk("t3_br_cnt", br_cnt, 4'd4);
    step();
    chk("t3_b_eval_off", b_eval, 1'b0);

    // JAL, bpu did not know it -> flush
    issue(3'd6, 32'h200, 32'hFFFF_FFF8, 0, 0, 32'd0, 32'd0, 0);
    chk("t4_trgt_gen", trgt_gen, 1'b1);
    chk("t4_alupc", alupc, 32'h1F8);
    step();
    chk("t4_flush1", flush, 1'b1);
    step();
    chk("t4_flush2", flush, 1'b1);
    step();
    chk("t4_flush_end", flush, 1'b0);

    // JAL known to the bpu -> no flush
    issue(3'd6, 32'h200, 32'hFFFF_FFF8, 0, 1, 32'd0, 32'd0, 0);
    chk("t4v_trgt_gen", trgt_gen, 1'b1);
    step();
    chk("t4v_no_flush", flush, 1'b0);

    // JALR, bit0 cleared
    issue(3'd7, 32'h600, 32'd4, 0, 1, 32'h301, 32'd0, 0);
    chk("t5_jr_bpu", jr_bpu, 1'b1);
    chk("t5_jr_in", jr_in, 32'h304);
    step();
    chk("t5_flush1", flush, 1'b1);

    // Randomised traffic
    for (int n = 0; n < 300; n++) begin
      k = 3'($urandom);
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = a ^ 32'h8000_0000;
        2: b = 32'($urandom_range(0, 7));
        default: b = $urandom;
      endcase
      imm = ($urandom_range(0, 1) == 1) ? 32'($signed(12'($urandom))) : $urandom;
      h = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
      issue(k, $urandom, imm, 1'($urandom), 1'($urandom), a, b, h);
    end

    // Saturation: a run of guaranteed mispredicts
    for (int n = 0; n < 20; n++) begin
      issue(3'd0, 32'h700, 32'h8, 0, 0, 32'd9, 32'd9, 0);
    end
    chk("sat_mis_cnt", mis_cnt, 4'hF);
    chk("sat_br_cnt", br_cnt, 4'hF);

    // Reset during a flush window
    issue(3'd7, 32'h800, 32'd0, 0, 1, 32'h1234, 32'd0, 0);
    step();
    chk("rf_flush_before", flush, 1'b1);
    nrst = 0;
    step();
    chk("rf_flush", flush, 1'b0);
    chk("rf_ready", in_ready, 1'b1);
    chk("rf_br_cnt", br_cnt, 4'h0);
    chk("rf_mis_cnt", mis_cnt, 4'h0);
    nrst = 1;

    issue(3'd0, 32'h100, 32'h20, 1, 0, 32'd5, 32'd5, 0);
    chk("post_rst_br_cnt", br_cnt, 4'd1);
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
